gpr_regfile: RTL and testbench

- General-purpose register file for the single-cycle RV64 core.
- Sits inside the instruction-decode stage: provides two combinational read ports (rs1, rs2) and one clocked write port (rd) fed by the execute result.
- The write target is chosen by a one-hot decoder built from a generic key-lookup mux; each register is a reset-able enable flop.
- x0 is hardwired to zero.

---
 rtl/gpr_regfile_pkg.sv | 8 +
 rtl/gpr_regfile_if.sv | 18 +
 rtl/gpr_regfile_cell.sv | 16 +
 rtl/gpr_regfile_key_mux.sv | 21 ++
 rtl/gpr_regfile.sv | 48 ++++
 tb/tb_gpr_regfile.sv | 170 +++++++++++++++++
 6 files changed

// File: rtl/gpr_regfile_pkg.sv
// Shared sizing constants for the RV64 general-purpose register file.
// REG_SEL must equal clog2(NR_REG).
package gpr_regfile_pkg;
  localparam int XLEN      = 64;
  localparam int NR_REG    = 32;
  localparam int REG_SEL   = 5;
  localparam logic [XLEN-1:0] RESET_VAL = '0;
endpackage

// File: rtl/gpr_regfile_if.sv
// Decode-stage port bundle: rd write port, two read ports and the debug view.
interface gpr_regfile_if;
  import gpr_regfile_pkg::*;

  logic                   wen;
  logic [REG_SEL-1:0]     rd;
  logic [XLEN-1:0]        wdata;
  logic [REG_SEL-1:0]     rs1;
  logic [REG_SEL-1:0]     rs2;
  logic [XLEN-1:0]        rdata1;
  logic [XLEN-1:0]        rdata2;
  logic [NR_REG*XLEN-1:0] dbg_regs;

  modport master (output wen, rd, wdata, rs1, rs2,
                  input  rdata1, rdata2, dbg_regs);
  modport slave  (input  wen, rd, wdata, rs1, rs2,
                  output rdata1, rdata2, dbg_regs);
endinterface

// File: rtl/gpr_regfile_cell.sv
// Single architectural register: enable flop with asynchronous active-low reset.
module gpr_regfile_cell #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= RESET_VAL;
    else if (en) q <= d;
  end
endmodule

// File: rtl/gpr_regfile_key_mux.sv
// Generic combinational key lookup; lut holds NR_KEY {key, data} pairs.
// Matching entries are OR-ed together, so no match yields zero.
module key_mux #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  output logic [DATA_LEN-1:0]                  data
);
  localparam int PAIR_W = KEY_LEN + DATA_LEN;

  always_comb begin
    data = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (lut[i*PAIR_W+DATA_LEN +: KEY_LEN] == key)
        data = data | lut[i*PAIR_W +: DATA_LEN];
    end
  end
endmodule

// File: rtl/gpr_regfile.sv
// RV64 GPR file: two combinational read ports, one clocked write port, x0 reads zero.
// The rd decoder is a key_mux whose table maps index 0 to an empty enable vector.
module gpr_regfile
  import gpr_regfile_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  gpr_regfile_if.slave  bus
);
  localparam int LUT_W = REG_SEL + NR_REG;

  logic [NR_REG*LUT_W-1:0] rd_lut;
  logic [NR_REG-1:0]       wr_onehot;
  logic [XLEN-1:0]         regs [NR_REG];

  for (genvar i = 0; i < NR_REG; i++) begin : g_lut
    localparam logic [NR_REG-1:0] ONEHOT = (i == 0) ? '0 : (NR_REG'(1) << i);
    assign rd_lut[i*LUT_W +: LUT_W] = {REG_SEL'(i), ONEHOT};
  end

  key_mux #(
    .NR_KEY   (NR_REG),
    .KEY_LEN  (REG_SEL),
    .DATA_LEN (NR_REG)
  ) u_rd_dec (
    .key  (bus.rd),
    .lut  (rd_lut),
    .data (wr_onehot)
  );

  for (genvar i = 0; i < NR_REG; i++) begin : g_reg
    gpr_regfile_cell #(
      .WIDTH     (XLEN),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .en  (bus.wen & wr_onehot[i]),
      .d   (bus.wdata),
      .q   (regs[i])
    );
    assign bus.dbg_regs[i*XLEN +: XLEN] = regs[i];
  end

  // x0 is forced to zero at the read ports regardless of RESET_VAL.
  assign bus.rdata1 = (bus.rs1 == '0) ? '0 : regs[bus.rs1];
  assign bus.rdata2 = (bus.rs2 == '0) ? '0 : regs[bus.rs2];
endmodule

// File: tb/tb_gpr_regfile.sv
// Directed bench for gpr_regfile; expectations queue into a scoreboard drained by a monitor.
module tb_gpr_regfile;
  import gpr_regfile_pkg::*;

  typedef struct {
    int          kind;   // 0: rdata1, 1: rdata2, 2: dbg_regs slice
    int          idx;
    logic [63:0] exp;
    string       nm;
  } exp_t;

  logic clk;
  logic rst;
  gpr_regfile_if bus ();

  gpr_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb [$];
  event        chk_ev;
  int          total = 0;
  int          bad   = 0;
  logic [63:0] mdl [32];
  exp_t        mon_it;
  logic [63:0] mon_got;

  initial begin
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        mon_it = sb.pop_front();
        case (mon_it.kind)
          0:       mon_got = bus.rdata1;
          1:       mon_got = bus.rdata2;
          default: mon_got = bus.dbg_regs[mon_it.idx*64 +: 64];
        endcase
        total++;
        if (mon_got !== mon_it.exp) begin
          bad++;
          $display("FAIL %s idx=%0d got=%h want=%h", mon_it.nm, mon_it.idx, mon_got, mon_it.exp);
        end
      end
    end
  end

  task automatic push(input int kind, input int idx, input logic [63:0] e, input string nm);
    exp_t it;
    it.kind = kind; it.idx = idx; it.exp = e; it.nm = nm;
    sb.push_back(it);
  endtask

  task automatic sample();
    -> chk_ev;
    #1;
  endtask

  task automatic push_all_model(input string nm);
    for (int i = 0; i < 32; i++) push(2, i, mdl[i], nm);
  endtask

  task automatic do_write(input logic en, input logic [4:0] r, input logic [63:0] d);
    @(negedge clk);
    bus.wen = en; bus.rd = r; bus.wdata = d;
    @(posedge clk);
    #1;
    if (en && r != 5'd0) mdl[r] = d;
    bus.wen = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.wen = 1'b0; bus.rd = '0; bus.wdata = '0; bus.rs1 = '0; bus.rs2 = '0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    push_all_model("por_dbg");
    sample();
    @(negedge clk); rst = 1'b1;

    // Preload, then assert reset between edges
    do_write(1'b1, 5'd2, 64'h0123_4567_89AB_CDEF);
    do_write(1'b1, 5'd9, 64'hCAFE_F00D_0000_0009);
    bus.rs1 = 5'd2; bus.rs2 = 5'd9; #1;
    push(0, 2, 64'h0123_4567_89AB_CDEF, "preload_rd1");
    push(1, 9, 64'hCAFE_F00D_0000_0009, "preload_rd2");
    sample();
    @(negedge clk); #2;
    rst = 1'b0; #1;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    push_all_model("async_rst_dbg");
    push(0, 2, 64'h0, "async_rst_rd1");
    push(1, 9, 64'h0, "async_rst_rd2");
    sample();
    @(negedge clk); rst = 1'b1;

    // Basic write/read
    do_write(1'b1, 5'd5, 64'hDEAD_BEEF_1234_5678);
    bus.rs1 = 5'd5; #1;
    push(0, 5, 64'hDEAD_BEEF_1234_5678, "basic_rd1");
    push_all_model("basic_dbg");
    sample();

    // x0 protection
    do_write(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.rs1 = 5'd0; #1;
    push(0, 0, 64'h0, "x0_rd1");
    push_all_model("x0_dbg");
    sample();

    // Write disabled
    do_write(1'b0, 5'd7, 64'h55);
    bus.rs1 = 5'd7; #1;
    push(0, 7, 64'h0, "wen0_rd1");
    push(2, 7, 64'h0, "wen0_dbg7");
    sample();

    // Read during write, no bypass
    do_write(1'b1, 5'd3, 64'h11);
    @(negedge clk);
    bus.rs2 = 5'd3; bus.rd = 5'd3; bus.wen = 1'b1; bus.wdata = 64'h22; #1;
    push(1, 3, 64'h11, "rdw_before");
    sample();
    @(posedge clk); #1;
    bus.wen = 1'b0; mdl[3] = 64'h22;
    push(1, 3, 64'h22, "rdw_after");
    sample();

    // Decoder sweep
    for (int k = 1; k < 32; k++) do_write(1'b1, 5'(k), 64'(k * 32'h0101));
    bus.rs1 = 5'd31; bus.rs2 = 5'd1; #1;
    push(0, 31, 64'h1F1F, "sweep_rd1");
    push(1, 1, 64'h0101, "sweep_rd2");
    for (int k = 1; k < 32; k++) push(2, k, 64'(k * 32'h0101), "sweep_dbg");
    push(2, 0, 64'h0, "sweep_dbg0");
    sample();

    // Reset held across an edge overrides a concurrent write
    @(negedge clk);
    bus.wen = 1'b1; bus.rd = 5'd4; bus.wdata = 64'hBADB_ADBA_DBAD_BADB; #2;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    push_all_model("rst_override_dbg");
    sample();
    @(negedge clk); bus.wen = 1'b0; rst = 1'b1;

    // Recovery write after reset
    do_write(1'b1, 5'd10, 64'hA5A5_5A5A_0F0F_F0F0);
    bus.rs1 = 5'd10; bus.rs2 = 5'd4; #1;
    push(0, 10, 64'hA5A5_5A5A_0F0F_F0F0, "recover_rd1");
    push(1, 4, 64'h0, "recover_rd2");
    push_all_model("recover_dbg");
    sample();

    #5;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
